// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers a host payload, then serializes one framed packet (da, sa, length, CRC, payload) to the router.
// Latency: byte0 leaves two cycles after the pl_last beat when busy_in is low and the inter-frame gap has expired.
// Backpressure: pl_ready is low from the pl_last beat until the frame has been sent; busy_in only holds off the frame start.
module router_pkt_tx #(
  parameter int MAX_PAYLOAD = 1990,
  parameter int ADDR_W      = 11,
  parameter int IFG         = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  da,
  input  logic [7:0]  sa,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  input  logic        pl_last,
  output logic        pl_ready,
  input  logic        crc_corrupt,
  input  logic        busy_in,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_busy,
  output logic        err_short,
  output logic        err_ovf,
  output logic [15:0] pkt_count,
  output logic [15:0] drop_count
);

  localparam int          GAP_W   = (IFG < 2) ? 1 : $clog2(IFG + 1);
  localparam logic [11:0] MAX_CNT = 12'(MAX_PAYLOAD);

  typedef enum logic [2:0] {LOAD, WAIT, HDR, PLD, GAP} state_t;
  state_t state;

  // Payload buffer; only written while loading, only read while sending.
  logic [7:0]        mem [0:(1 << ADDR_W) - 1];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [7:0]        rd_dat;

  logic [11:0]      cnt;
  logic [11:0]      plen;
  logic [11:0]      pld_idx;
  logic [31:0]      crc_acc;
  logic [31:0]      crc_r;
  logic [31:0]      len_r;
  logic             ovf;
  logic             corrupt_r;
  logic [7:0]       da_r;
  logic [7:0]       sa_r;
  logic [3:0]       hdr_idx;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       hdr_byte;

  logic        beat;
  logic        store;
  logic        ovf_inc;
  logic [11:0] cnt_inc;
  logic [31:0] crc_inc;

  // Values the load counters take if the current beat is accepted.
  assign beat    = pl_valid && pl_ready && (state == LOAD);
  assign store   = cnt < MAX_CNT;
  assign ovf_inc = ovf || !store;
  assign cnt_inc = (cnt == 12'hFFF) ? cnt : cnt + 12'd1;
  assign crc_inc = crc_acc + {24'd0, pl_data};

  // Header byte selected by position: addresses, then length and CRC little-endian.
  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx)
      4'd0:    hdr_byte = da_r;
      4'd1:    hdr_byte = sa_r;
      4'd2:    hdr_byte = len_r[7:0];
      4'd3:    hdr_byte = len_r[15:8];
      4'd4:    hdr_byte = len_r[23:16];
      4'd5:    hdr_byte = len_r[31:24];
      4'd6:    hdr_byte = crc_r[7:0] ^ {7'd0, corrupt_r};
      4'd7:    hdr_byte = crc_r[15:8];
      4'd8:    hdr_byte = crc_r[23:16];
      4'd9:    hdr_byte = crc_r[31:24];
      default: hdr_byte = 8'h00;
    endcase
  end

  // Buffer write on stored beats and a registered read that runs one byte ahead of the output.
  always_ff @(posedge clk) begin
    if (beat && store) begin
      mem[wr_ptr] <= pl_data;
    end
    rd_dat <= mem[rd_ptr];
  end

  // Transmit FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= LOAD;
      pl_ready   <= 1'b1;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      tx_busy    <= 1'b0;
      err_short  <= 1'b0;
      err_ovf    <= 1'b0;
      pkt_count  <= 16'd0;
      drop_count <= 16'd0;
      gap_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= 12'd0;
      plen       <= 12'd0;
      pld_idx    <= 12'd0;
      crc_acc    <= 32'd0;
      crc_r      <= 32'd0;
      len_r      <= 32'd0;
      ovf        <= 1'b0;
      corrupt_r  <= 1'b0;
      da_r       <= 8'h00;
      sa_r       <= 8'h00;
      hdr_idx    <= 4'd0;
    end else begin
      err_short <= 1'b0;
      err_ovf   <= 1'b0;
      // The gap counter runs in every state so the next payload can load during the gap.
      if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
      case (state)
        LOAD: begin
          if (beat) begin
            cnt     <= cnt_inc;
            crc_acc <= crc_inc;
            ovf     <= ovf_inc;
            if (store) begin
              wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pl_last) begin
              // Every outcome of the last beat starts the next packet from an empty buffer.
              cnt     <= 12'd0;
              crc_acc <= 32'd0;
              ovf     <= 1'b0;
              wr_ptr  <= '0;
              if (ovf_inc) begin
                err_ovf    <= 1'b1;
                drop_count <= drop_count + 16'd1;
              end else if (cnt_inc < 12'd2) begin
                err_short  <= 1'b1;
                drop_count <= drop_count + 16'd1;
              end else begin
                da_r      <= da;
                sa_r      <= sa;
                corrupt_r <= crc_corrupt;
                plen      <= cnt_inc;
                len_r     <= {20'd0, cnt_inc} + 32'd10;
                crc_r     <= crc_inc;
                hdr_idx   <= 4'd0;
                pld_idx   <= 12'd0;
                rd_ptr    <= '0;
                state     <= WAIT;
                pl_ready  <= 1'b0;
                tx_busy   <= 1'b1;
              end
            end
          end
        end
        WAIT: begin
          if (!busy_in && (gap_cnt == '0)) begin
            state <= HDR;
          end
        end
        HDR: begin
          tx_valid <= 1'b1;
          tx_data  <= hdr_byte;
          hdr_idx  <= hdr_idx + 4'd1;
          if (hdr_idx == 4'd9) begin
            // rd_dat already holds byte 0; step the read so byte 1 is ready for the first payload cycle.
            rd_ptr <= rd_ptr + ADDR_W'(1);
            state  <= PLD;
          end
        end
        PLD: begin
          tx_data <= rd_dat;
          rd_ptr  <= rd_ptr + ADDR_W'(1);
          pld_idx <= pld_idx + 12'd1;
          if (pld_idx == plen - 12'd1) begin
            pkt_count <= pkt_count + 16'd1;
            gap_cnt   <= GAP_W'(IFG);
            state     <= GAP;
          end
        end
        GAP: begin
          tx_valid <= 1'b0;
          tx_data  <= 8'h00;
          state    <= LOAD;
          pl_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
        default: begin
          state    <= LOAD;
          pl_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
